// File: rtl/fc_1st_mac_engine_if.sv
// Result stream of the first-layer FC MAC engine.
// Valid/ready handshake carrying one signed result per neuron.
interface fc_1st_mac_engine_if #(
    parameter int Bit_width = 16
);
    logic                 Out_Valid;
    logic                 Out_Ready;
    logic [Bit_width-1:0] Out_Data;

    modport master (
        output Out_Valid,
        output Out_Data,
        input  Out_Ready
    );

    modport slave (
        input  Out_Valid,
        input  Out_Data,
        output Out_Ready
    );
endinterface

// File: rtl/fc_1st_mac_engine.sv
// First FC layer MAC engine: 5-wide dot products, bias, saturation.
// Optional ReLU on the result when FC1_RELU_EN is defined.
module fc_1st_mac_engine #(
    parameter int Bit_width   = 16,
    parameter int Frac_bits   = 8,
    parameter int In_Len      = 32,
    parameter int Out_Len     = 16,
    parameter int Waddr_width = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        Start,
    output logic                        Busy,
    output logic                        Done,
    output logic                        Read_Enable,
    output logic [4:0]                  Read_Width,
    input  logic signed [Bit_width-1:0] data_in_0,
    input  logic signed [Bit_width-1:0] data_in_1,
    input  logic signed [Bit_width-1:0] data_in_2,
    input  logic signed [Bit_width-1:0] data_in_3,
    input  logic signed [Bit_width-1:0] data_in_4,
    output logic [Waddr_width-1:0]      Weight_Addr,
    input  logic signed [Bit_width-1:0] weight_in_0,
    input  logic signed [Bit_width-1:0] weight_in_1,
    input  logic signed [Bit_width-1:0] weight_in_2,
    input  logic signed [Bit_width-1:0] weight_in_3,
    input  logic signed [Bit_width-1:0] weight_in_4,
    output logic [3:0]                  Neuron_Idx,
    input  logic signed [Bit_width-1:0] bias_in,
    fc_1st_mac_engine_if.master         out_bus
);
    localparam int PROD_W = 2 * Bit_width;
    localparam int ACC_W  = PROD_W + 4;
    localparam int SUM_W  = ACC_W + 2;

    localparam logic [2:0] LAST_STEP = 3'((In_Len + 4) / 5 - 1);
    localparam logic [3:0] LAST_NEU  = 4'(Out_Len - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;
    localparam logic [1:0] S_OUT    = 2'd3;

    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-Bit_width+1){1'b0}}, {(Bit_width-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]                  state;
    logic [2:0]                  step;
    logic [Waddr_width-1:0]      nbase;
    logic signed [ACC_W-1:0]     acc;
    logic                        out_valid_q;
    logic [Bit_width-1:0]        out_data_q;

    logic signed [Bit_width-1:0] dvec [5];
    logic signed [Bit_width-1:0] wvec [5];
    logic signed [PROD_W-1:0]    prod [5];
    logic signed [ACC_W-1:0]     dot;
    logic signed [SUM_W-1:0]     acc_sx;
    logic signed [SUM_W-1:0]     bias_sx;
    logic signed [SUM_W-1:0]     sum;
    logic signed [SUM_W-1:0]     res;
    logic [Bit_width-1:0]        sat;
    logic [Bit_width-1:0]        result;

    assign dvec[0] = data_in_0;
    assign dvec[1] = data_in_1;
    assign dvec[2] = data_in_2;
    assign dvec[3] = data_in_3;
    assign dvec[4] = data_in_4;
    assign wvec[0] = weight_in_0;
    assign wvec[1] = weight_in_1;
    assign wvec[2] = weight_in_2;
    assign wvec[3] = weight_in_3;
    assign wvec[4] = weight_in_4;

    // Lanes past the RAM end come back as zero, so no masking here.
    always_comb begin
        dot = '0;
        for (int i = 0; i < 5; i++) begin
            prod[i] = dvec[i] * wvec[i];
            dot = dot + {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
        end
    end

    always_comb begin
        acc_sx  = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
        bias_sx = {{(SUM_W-Bit_width){bias_in[Bit_width-1]}}, bias_in};
        sum     = acc_sx + (bias_sx <<< Frac_bits);
        res     = sum >>> Frac_bits;
        if (res > SAT_MAX) begin
            sat = SAT_MAX[Bit_width-1:0];
        end else if (res < SAT_MIN) begin
            sat = SAT_MIN[Bit_width-1:0];
        end else begin
            sat = res[Bit_width-1:0];
        end
`ifdef FC1_RELU_EN
        result = sat[Bit_width-1] ? '0 : sat;
`else
        result = sat;
`endif
    end

    assign Busy              = (state != S_IDLE);
    assign out_bus.Out_Valid = out_valid_q;
    assign out_bus.Out_Data  = out_data_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            step        <= '0;
            nbase       <= '0;
            acc         <= '0;
            Neuron_Idx  <= '0;
            Done        <= 1'b0;
            Read_Enable <= 1'b0;
            Read_Width  <= '0;
            Weight_Addr <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        state       <= S_FETCH;
                        step        <= '0;
                        nbase       <= '0;
                        acc         <= '0;
                        Neuron_Idx  <= '0;
                        Read_Enable <= 1'b1;
                        Read_Width  <= '0;
                        Weight_Addr <= '0;
                    end
                end
                S_FETCH: begin
                    acc <= acc + dot;
                    if (step == LAST_STEP) begin
                        state       <= S_FINISH;
                        Read_Enable <= 1'b0;
                    end else begin
                        step        <= step + 3'd1;
                        Read_Width  <= Read_Width + 5'd5;
                        Weight_Addr <= Weight_Addr + Waddr_width'(1);
                    end
                end
                S_FINISH: begin
                    out_data_q  <= result;
                    out_valid_q <= 1'b1;
                    state       <= S_OUT;
                end
                default: begin
                    if (out_valid_q && out_bus.Out_Ready) begin
                        out_valid_q <= 1'b0;
                        if (Neuron_Idx == LAST_NEU) begin
                            Done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            // Next neuron's first read goes out on the handshake edge.
                            state       <= S_FETCH;
                            Neuron_Idx  <= Neuron_Idx + 4'd1;
                            step        <= '0;
                            acc         <= '0;
                            nbase       <= nbase + Waddr_width'(7);
                            Weight_Addr <= nbase + Waddr_width'(7);
                            Read_Enable <= 1'b1;
                            Read_Width  <= '0;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fc_1st_mac_engine.sv
// Directed bench for fc_1st_mac_engine: table of uniform passes,
// address-sensitive pass with backpressure, zero padding and reset.
module tb_fc_1st_mac_engine;
`ifdef FC1_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              Start;
    logic              Busy;
    logic              Done;
    logic              Read_Enable;
    logic [4:0]        Read_Width;
    logic signed [15:0] din [5];
    logic [7:0]        Weight_Addr;
    logic signed [15:0] win [5];
    logic [3:0]        Neuron_Idx;
    logic signed [15:0] bias_in;

    logic signed [15:0] mem   [32];
    logic signed [15:0] wrom  [112][5];
    logic signed [15:0] biasm [16];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] first_out;

    fc_1st_mac_engine_if #(.Bit_width(16)) ob ();

    fc_1st_mac_engine dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start),
        .Busy(Busy), .Done(Done),
        .Read_Enable(Read_Enable), .Read_Width(Read_Width),
        .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]),
        .data_in_3(din[3]), .data_in_4(din[4]),
        .Weight_Addr(Weight_Addr),
        .weight_in_0(win[0]), .weight_in_1(win[1]), .weight_in_2(win[2]),
        .weight_in_3(win[3]), .weight_in_4(win[4]),
        .Neuron_Idx(Neuron_Idx), .bias_in(bias_in),
        .out_bus(ob)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // RAM and ROM models sample on the negedge between engine edges.
    always @(negedge CLK) begin
        if (Read_Enable) begin
            for (int i = 0; i < 5; i++) begin
                int a;
                a = int'(Read_Width) + i;
                din[i] <= (a < 32) ? mem[a] : 16'sd0;
            end
        end
        for (int i = 0; i < 5; i++) begin
            win[i] <= (int'(Weight_Addr) < 112) ? wrom[Weight_Addr][i] : 16'sd0;
        end
    end
    assign bias_in = biasm[Neuron_Idx];

    typedef struct {
        string       name;
        logic [15:0] d;
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    function automatic logic [15:0] model(input int n);
        longint s;
        s = 0;
        for (int j = 0; j < 32; j++)
            s += longint'(mem[j]) * longint'(wrom[n*7 + j/5][j%5]);
        s += longint'(biasm[n]) * 256;
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (RELU && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic fill(input logic [15:0] d, input logic [15:0] w,
                        input logic [15:0] b);
        for (int j = 0; j < 32; j++) mem[j] = d;
        for (int a = 0; a < 112; a++)
            for (int l = 0; l < 5; l++) wrom[a][l] = w;
        for (int n = 0; n < 16; n++) biasm[n] = b;
    endtask

    task automatic run_pass(input string nm, input bit use_const,
                            input logic [15:0] cval, input bit timing,
                            input bit bp);
        int t0;
        int k;
        logic [15:0] hold;
        @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        t0 = cyc;
        chk({nm, " busy"}, {31'd0, Busy}, 32'd1);
        for (int n = 0; n < 16; n++) begin
            k = 0;
            while (!ob.Out_Valid && k < 40) begin
                @(negedge CLK);
                k++;
            end
            if (!ob.Out_Valid) begin
                timeout({nm, " valid"});
                return;
            end
            if (n == 0) first_out = ob.Out_Data;
            if (n == 0 && timing)
                chk({nm, " latency"}, 32'(cyc - t0), 32'd8);
            chk($sformatf("%s data n%0d", nm, n), {16'd0, ob.Out_Data},
                {16'd0, use_const ? cval : model(n)});
            if (bp && n == 2) begin
                ob.Out_Ready = 1'b0;
                hold = ob.Out_Data;
                for (int i = 0; i < 5; i++) begin
                    @(negedge CLK);
                    if (i == 1) Start = 1'b1;
                    if (i == 2) Start = 1'b0;
                    chk($sformatf("bp hold c%0d", i), {16'd0, ob.Out_Data},
                        {16'd0, hold});
                    chk($sformatf("bp re c%0d", i), {31'd0, Read_Enable}, 32'd0);
                    chk($sformatf("bp idx c%0d", i), {28'd0, Neuron_Idx}, 32'd2);
                    chk($sformatf("bp valid c%0d", i), {31'd0, ob.Out_Valid}, 32'd1);
                end
                ob.Out_Ready = 1'b1;
            end
            @(negedge CLK);
            if (n < 15) begin
                chk($sformatf("%s idx n%0d", nm, n + 1), {28'd0, Neuron_Idx},
                    32'(n + 1));
            end else begin
                chk({nm, " done"}, {31'd0, Done}, 32'd1);
                chk({nm, " idle"}, {31'd0, Busy}, 32'd0);
                if (timing) chk({nm, " pass cycles"}, 32'(cyc - t0), 32'd144);
                @(negedge CLK);
                chk({nm, " done pulse"}, {31'd0, Done}, 32'd0);
            end
        end
    endtask

    vec_t tbl [7];

    initial begin
        int k;
        tbl[0] = '{"ones",   16'h0100, 16'h0100, 16'h0000, 16'h2000};
        tbl[1] = '{"satpos", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        tbl[2] = '{"negbias",16'h0000, 16'h0100, 16'hFF00,
                   RELU ? 16'h0000 : 16'hFF00};
        tbl[3] = '{"negw",   16'h0100, 16'hFF00, 16'h0000,
                   RELU ? 16'h0000 : 16'hE000};
        tbl[4] = '{"satneg", 16'h7FFF, 16'h8000, 16'h0000,
                   RELU ? 16'h0000 : 16'h8000};
        tbl[5] = '{"frac",   16'h0100, 16'h0080, 16'h0180, 16'h1180};
        tbl[6] = '{"floor",  16'h0001, 16'h0001, 16'hFFFF,
                   RELU ? 16'h0000 : 16'hFFFF};

        RST_N = 1'b0;
        Start = 1'b0;
        ob.Out_Ready = 1'b1;
        fill(16'h0000, 16'h0000, 16'h0000);
        repeat (3) @(negedge CLK);
        chk("rst busy", {31'd0, Busy}, 32'd0);
        chk("rst valid", {31'd0, ob.Out_Valid}, 32'd0);
        chk("rst re", {31'd0, Read_Enable}, 32'd0);
        RST_N = 1'b1;

        for (int r = 0; r < 7; r++) begin
            fill(tbl[r].d, tbl[r].w, tbl[r].b);
            run_pass(tbl[r].name, 1'b1, tbl[r].exp, r == 0, 1'b0);
        end

        // Distinct weights and bias per neuron exercise the addressing.
        for (int j = 0; j < 32; j++) mem[j] = 16'(j * 16 - 200);
        for (int a = 0; a < 112; a++)
            for (int l = 0; l < 5; l++) wrom[a][l] = 16'((a * 5 + l) * 9 - 700);
        for (int n = 0; n < 16; n++) biasm[n] = 16'(n * 64 - 512);
        run_pass("addr", 1'b0, 16'h0000, 1'b0, 1'b1);

        fill(16'h0000, 16'h7FFF, 16'h0000);
        mem[30] = 16'h0100;
        mem[31] = 16'h0100;
        wrom[6][0] = 16'h0100;
        wrom[6][1] = 16'h0100;
        run_pass("pad", 1'b0, 16'h0000, 1'b0, 1'b0);
        chk("pad n0 const", {16'd0, first_out}, 32'h0000_0200);

        fill(16'h0100, 16'h0100, 16'h0000);
        @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        k = 0;
        while (!(Neuron_Idx == 4'd3 && Read_Enable && Read_Width == 5'd15)
               && k < 200) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 200) timeout("reach n3 s3");
        RST_N = 1'b0;
        @(negedge CLK);
        chk("mrst busy", {31'd0, Busy}, 32'd0);
        chk("mrst done", {31'd0, Done}, 32'd0);
        chk("mrst re", {31'd0, Read_Enable}, 32'd0);
        chk("mrst rw", {27'd0, Read_Width}, 32'd0);
        chk("mrst wa", {24'd0, Weight_Addr}, 32'd0);
        chk("mrst valid", {31'd0, ob.Out_Valid}, 32'd0);
        chk("mrst data", {16'd0, ob.Out_Data}, 32'd0);
        chk("mrst idx", {28'd0, Neuron_Idx}, 32'd0);
        RST_N = 1'b1;
        run_pass("after rst", 1'b1, 16'h2000, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
